// File: rtl/ram_burst_initiator.sv
// ram_burst_initiator
//
// Drives the data port of the byte-addressed dual-port RAM model with 32-bit
// word bursts. It can do pattern fills, incrementing-pattern writes, and
// read-back checks that also produce a checksum. The block takes one command
// at a time over a valid/ready handshake and issues one access per cycle.
// Read data from the RAM is registered, so it is consumed one cycle after
// each read access.
//
// Optional feature macro: RAM_BURST_INITIATOR_ABORT_EN
//   When this macro is defined, the block gets an abort_i port.
//   - abort_i in WRITE ends the burst after the current access.
//   - abort_i in READ stops issuing reads, then drains the one outstanding
//     read before finishing.
//
// Ports
//   clk_i, rst_ni      clock (rising edge) and asynchronous active-low reset
//   cmd_valid_i/ready  command handshake; ready is high only in IDLE
//   cmd_op_i           00 WFILL, 01 WINCR, 10 RFILL, 11 RINCR
//   cmd_addr_i         start byte address (bits [1:0] ignored)
//   cmd_len_i          burst length in words (0 allowed)
//   cmd_pattern_i      fill value / increment base
//   mem_*              RAM data-port access signals; mem_rdata_i is one cycle late
//   busy_o, done_o     activity flag and one-cycle completion pulse
//   err_o, err_addr_o, err_count_o, sum_o  results of the last check command

module ram_burst_initiator #(
  parameter int ADDR_WIDTH = 22,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [CNT_WIDTH-1:0]  cmd_len_i,
  input  logic [31:0]           cmd_pattern_i,
`ifdef RAM_BURST_INITIATOR_ABORT_EN
  input  logic                  abort_i,
`endif
  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [CNT_WIDTH-1:0]  err_count_o,
  output logic [31:0]           sum_o
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);

  state_e                state_q;
  logic                  op_incr_q;
  logic [CNT_WIDTH-1:0]  remain_q;     // words still to issue after the current one
  logic [31:0]           cur_word_q;   // expected/written word for the current access
  logic                  rd_pend_q;    // a read was issued last cycle; its data is on mem_rdata_i
  logic [31:0]           pend_exp_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;
  logic                  abort_req;
  logic                  last_issue;
  logic [31:0]           next_word;

`ifdef RAM_BURST_INITIATOR_ABORT_EN
  assign abort_req = abort_i;
`else
  assign abort_req = 1'b0;
`endif

  assign last_issue = (remain_q == '0) || abort_req;
  assign next_word  = op_incr_q ? cur_word_q + 32'd1 : cur_word_q;

  // Single control FSM. Read data is retired one cycle after its access, so
  // the retire logic runs ahead of the state case; this lets the DRAIN cycle
  // account for the final read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      op_incr_q   <= 1'b0;
      remain_q    <= '0;
      cur_word_q  <= '0;
      rd_pend_q   <= 1'b0;
      pend_exp_q  <= '0;
      pend_addr_q <= '0;
      cmd_ready_o <= 1'b1;
      mem_en_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'h0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_addr_o  <= '0;
      err_count_o <= '0;
      sum_o       <= '0;
    end else begin
      done_o    <= 1'b0;
      rd_pend_q <= 1'b0;

      if (rd_pend_q) begin
        sum_o <= sum_o + mem_rdata_i;
        if (mem_rdata_i != pend_exp_q) begin
          err_o <= 1'b1;
          if (!err_o) begin
            err_addr_o <= pend_addr_q;
          end
          if (err_count_o != '1) begin
            err_count_o <= err_count_o + CNT_ONE;
          end
        end
      end

      case (state_q)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            op_incr_q   <= cmd_op_i[0];
            cur_word_q  <= cmd_pattern_i;
            remain_q    <= cmd_len_i - CNT_ONE;
            mem_addr_o  <= cmd_addr_i & ALIGN_MASK;
            err_o       <= 1'b0;
            err_addr_o  <= '0;
            err_count_o <= '0;
            sum_o       <= '0;
            if (cmd_len_i == '0) begin
              state_q <= DONE;
              done_o  <= 1'b1;
            end else if (cmd_op_i[1]) begin
              state_q  <= READ;
              mem_en_o <= 1'b1;
              mem_we_o <= 1'b0;
              mem_be_o <= 4'h0;
            end else begin
              state_q     <= WRITE;
              mem_en_o    <= 1'b1;
              mem_we_o    <= 1'b1;
              mem_be_o    <= 4'hF;
              mem_wdata_o <= cmd_pattern_i;
            end
          end
        end

        WRITE: begin
          if (last_issue) begin
            state_q     <= DONE;
            done_o      <= 1'b1;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'h0;
            mem_wdata_o <= '0;
          end else begin
            remain_q    <= remain_q - CNT_ONE;
            mem_addr_o  <= mem_addr_o + ADDR_STEP;
            cur_word_q  <= next_word;
            mem_wdata_o <= next_word;
          end
        end

        READ: begin
          rd_pend_q   <= 1'b1;
          pend_exp_q  <= cur_word_q;
          pend_addr_q <= mem_addr_o;
          if (last_issue) begin
            state_q  <= DRAIN;
            mem_en_o <= 1'b0;
          end else begin
            remain_q   <= remain_q - CNT_ONE;
            mem_addr_o <= mem_addr_o + ADDR_STEP;
            cur_word_q <= next_word;
          end
        end

        DRAIN: begin
          state_q <= DONE;
          done_o  <= 1'b1;
        end

        DONE: begin
          state_q     <= IDLE;
          busy_o      <= 1'b0;
          cmd_ready_o <= 1'b1;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_burst_initiator.md
# ram_burst_initiator

Testbench-side initiator that drives the data port of the team's byte-addressed dual-port RAM model with word bursts: pattern fills, incrementing-pattern writes, and read-back checks with checksum. It accepts one command at a time over a valid/ready handshake, issues one 32-bit access per cycle, and consumes the RAM's one-cycle registered read data. Used for memory pre-initialisation and post-run scrubbing, without DPI backdoor access.

## Interface
- ADDR_WIDTH, 22, byte-address width; must match the attached RAM.
- CNT_WIDTH, 16, width of the burst length and error counter.

- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  block can accept a command (IDLE only).
- cmd_op_i  in  2  00 WFILL, 01 WINCR, 10 RFILL (check), 11 RINCR (check).
- cmd_addr_i  in  ADDR_WIDTH  start byte address; bits [1:0] ignored.
- cmd_len_i  in  CNT_WIDTH  number of 32-bit words; 0 allowed.
- cmd_pattern_i  in  32  fill value / increment base.
- mem_en_o  out  1  RAM access enable.
- mem_addr_o  out  ADDR_WIDTH  word-aligned byte address.
- mem_wdata_o  out  32  write data.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_be_o  out  4  byte enables; 4'hF for every write, 4'h0 for reads.
- mem_rdata_i  in  32  RAM read data, valid the cycle after a read access.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  at least one compare mismatch in the last check command.
- err_addr_o  out  ADDR_WIDTH  address of first mismatch.
- err_count_o  out  CNT_WIDTH  mismatch count, saturating at all-ones.
- sum_o  out  32  sum mod 2^32 of all words read by the last read command.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- Command acceptance: IDLE with cmd_valid_i & cmd_ready_o. Latches op, addr ({addr[ADDR_WIDTH-1:2],2'b00}), len, pattern. Clears err_o, err_addr_o, err_count_o, sum_o.
- Transitions on acceptance: len==0 -> DONE. Write op -> WRITE. Read op -> READ.
- Expected word k (k=0..len-1): FILL = pattern. INCR = pattern + k, mod 2^32.
- WRITE: one write per cycle at addr+4k with word k. After word len-1 -> DONE.
- READ: one read per cycle at addr+4k. After word len-1 -> DRAIN.
- DRAIN: consumes the last read word, then -> DONE.
- Read-data handling: the cycle after each read, sum_o += mem_rdata_i and mem_rdata_i is compared with expected word k.
- On mismatch: err_o set; err_count_o increments (saturating); err_addr_o is captured only on the first mismatch.
- Address arithmetic wraps modulo 2^ADDR_WIDTH, e.g. 0x...FC -> 0x000.
- DONE: done_o=1 for exactly one cycle, then -> IDLE.
- cmd_valid_i while busy: ignored (ready low); the command is held upstream.
- Result outputs (err_*, sum_o) hold until the next command is accepted.

## Timing
- All outputs are registered.
- Reset values: cmd_ready_o=1; every other output 0, including mem_be_o and mem_addr_o.
- Assertion of rst_ni low forces IDLE asynchronously, mid-burst included. mem_en_o drops immediately; the partial burst is abandoned; results are cleared.
- Accept at edge E0. First access (mem_en_o=1) is in cycle 1.
- Write of N words: accesses in cycles 1..N; done_o in cycle N+1.
- Read of N words: accesses in cycles 1..N, DRAIN in cycle N+1, done_o in cycle N+2. sum_o and err_* are final when done_o is high.
- len=0: done_o in cycle 1; no memory access.
- Earliest next acceptance is the cycle after done_o. Back-to-back commands have one dead cycle.
- mem_en_o is low outside WRITE/READ. mem_wdata_o is 0 when not writing.

## Configuration
- RAM_BURST_INITIATOR_ABORT_EN defined: adds an input port abort_i (1 bit).
  - abort_i high in WRITE: stops issuing after the current cycle, -> DONE.
  - abort_i high in READ: stops issuing, -> DRAIN, so the one outstanding read is still summed and compared, then DONE.
  - In IDLE, DRAIN or DONE, abort_i is ignored.
- Not defined: no abort_i port; every burst runs to completion.

## Test plan
- WFILL addr 0x100, len 4, pattern 0xDEADBEEF -> mem_en_o in cycles 1-4 at 0x100/104/108/10C, we=1, be=F; done_o in cycle 5; RAM words read back 0xDEADBEEF.
- WINCR 0x200, len 3, pattern 0xFFFFFFFE, then RINCR same -> writes FFFFFFFE/FFFFFFFF/00000000. Read: done_o in cycle 5, err_o=0, sum_o=0xFFFFFFFD.
- After the above, corrupt 0x204 to 0 via port a, then RINCR -> err_o=1, err_addr_o=0x204, err_count_o=1, sum_o=0xFFFFFFFE.
- len=0 -> done_o in cycle 1, mem_en_o never high. Unaligned start 0x103 -> first access at 0x100.
- ADDR_WIDTH=8, WFILL at 0xFC, len 2 -> addresses 0xFC then 0x00. A second cmd_valid_i while busy stays unaccepted until after done_o.
- rst_ni low in cycle 2 of a 4-word READ -> mem_en_o low immediately, cmd_ready_o=1, sum_o=0. With the macro defined, abort_i high in cycle 2 of READ len 8 -> reads in cycles 1-2, done_o in cycle 4.
